// File: rtl/byte_striping.sv
// byte_striping: deals a single 32-bit word stream onto two lanes.
// Consecutive accepted words alternate lane_0 / lane_1, starting on lane_0.
// Each lane output is registered, so a word appears one cycle after it is accepted.
// Optional build macro STRIPE_REALIGN_EN: every new burst starts on lane_0 after a gap.
// Without it, lane alternation runs on continuously across gaps.
module byte_striping #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1,
  output logic              pair_done,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int NUM_LANES = 2;

  typedef enum logic {IDLE, STRIPE} state_e;

  state_e                             state_q;
  logic                               sel_q, sel_d;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_q;
  logic [NUM_LANES-1:0]               vld_q;
  logic                               pair_q;
  logic [CNT_W-1:0]                   cnt_q;

  // Next lane select: toggle per accepted word; a gap optionally realigns to lane_0.
  always_comb begin
    sel_d = sel_q;
    if (valid_in)
      sel_d = ~sel_q;
`ifdef STRIPE_REALIGN_EN
    else if (state_q == STRIPE)
      sel_d = 1'b0;
`endif
  end

  // Burst tracker; it only matters for gap handling, the data path ignores it.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= valid_in ? STRIPE : IDLE;
      sel_q   <= sel_d;
    end
  end

  // Per-lane word and qualifier registers; the data register holds while its lane is idle.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
        lane_q[g] <= '0;
        vld_q[g]  <= 1'b0;
      end else begin
        vld_q[g] <= valid_in && (sel_q == 1'(g));
        if (valid_in && (sel_q == 1'(g)))
          lane_q[g] <= data_in;
      end
    end
  end

  // Pair completion pulse and free-running word counter (wraps silently).
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      pair_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pair_q <= valid_in && sel_q;
      if (valid_in)
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign lane_0    = lane_q[0];
  assign lane_1    = lane_q[1];
  assign valid_0   = vld_q[0];
  assign valid_1   = vld_q[1];
  assign pair_done = pair_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: vector table plus hand sequences for
// async reset mid-burst, counter wrap (CNT_W=4 instance) and a loopback order check.
module tb_byte_striping;

  logic        clk;
  logic        reset, valid_in;
  logic [31:0] data_in;
  logic [31:0] lane_0, lane_1;
  logic        valid_0, valid_1, pair_done;
  logic [15:0] word_cnt;

  logic        reset4, valid4;
  logic [31:0] data4, lane4_0, lane4_1;
  logic        v4_0, v4_1, pd4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  byte_striping #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk_2f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(lane_0), .valid_0(valid_0), .lane_1(lane_1), .valid_1(valid_1),
    .pair_done(pair_done), .word_cnt(word_cnt));

  byte_striping #(.DATA_W(32), .CNT_W(4)) u_dut4 (
    .clk_2f(clk), .reset(reset4), .data_in(data4), .valid_in(valid4),
    .lane_0(lane4_0), .valid_0(v4_0), .lane_1(lane4_1), .valid_1(v4_1),
    .pair_done(pd4), .word_cnt(cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic [31:0] l0;
    logic        v0;
    logic [31:0] l1;
    logic        v1;
    logic        pd;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic [31:0] d, logic [31:0] l0, logic v0,
                              logic [31:0] l1, logic v1, logic pd, logic [15:0] cnt);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.l0 = l0; t.v0 = v0;
    t.l1 = l1; t.v1 = v1; t.pd = pd; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d);
    @(negedge clk);
    reset = r; valid_in = v; data_in = d;
    @(posedge clk);
    #1;
    chk("excl", {31'd0, valid_0 & valid_1}, 32'd0);
  endtask

  initial begin
    logic [31:0] sent[$];
    logic [31:0] got[$];
    logic [31:0] w;
    logic        gap_pat [11];

    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    reset4 = 1'b1; valid4 = 1'b0; data4 = '0;

    // Test 1: reset held with valid_in toggling
    tbl.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0));
    // Test 2: A0,B1,C2,D3 back-to-back
    tbl.push_back(mk(0, 1, 32'hA0, 32'hA0, 1, 0,     0, 0, 1));
    tbl.push_back(mk(0, 1, 32'hB1, 32'hA0, 0, 32'hB1, 1, 1, 2));
    tbl.push_back(mk(0, 1, 32'hC2, 32'hC2, 1, 32'hB1, 0, 0, 3));
    tbl.push_back(mk(0, 1, 32'hD3, 32'hC2, 0, 32'hD3, 1, 1, 4));
    // Test 3: odd burst 11,22,33, two-cycle gap with garbage data, then 44, 55
    tbl.push_back(mk(0, 1, 32'h11, 32'h11, 1, 32'hD3, 0, 0, 5));
    tbl.push_back(mk(0, 1, 32'h22, 32'h11, 0, 32'h22, 1, 1, 6));
    tbl.push_back(mk(0, 1, 32'h33, 32'h33, 1, 32'h22, 0, 0, 7));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF, 32'h33, 0, 32'h22, 0, 0, 7));
    tbl.push_back(mk(0, 0, 32'h5A5A5A5A, 32'h33, 0, 32'h22, 0, 0, 7));
`ifdef STRIPE_REALIGN_EN
    tbl.push_back(mk(0, 1, 32'h44, 32'h44, 1, 32'h22, 0, 0, 8));
    tbl.push_back(mk(0, 1, 32'h55, 32'h44, 0, 32'h55, 1, 1, 9));
`else
    tbl.push_back(mk(0, 1, 32'h44, 32'h33, 0, 32'h44, 1, 1, 8));
    tbl.push_back(mk(0, 1, 32'h55, 32'h55, 1, 32'h44, 0, 0, 9));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_lane0", lane_0, 32'd0);
    chk("rst_valid", {29'd0, valid_0, valid_1, pair_done}, 32'd0);
    chk("rst_cnt",   {16'd0, word_cnt}, 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d);
      chk($sformatf("v%0d_lane0", i), lane_0, tbl[i].l0);
      chk($sformatf("v%0d_lane1", i), lane_1, tbl[i].l1);
      chk($sformatf("v%0d_v0v1pd", i), {29'd0, valid_0, valid_1, pair_done},
          {29'd0, tbl[i].v0, tbl[i].v1, tbl[i].pd});
      chk($sformatf("v%0d_cnt", i), {16'd0, word_cnt}, {16'd0, tbl[i].cnt});
    end

    // Test 4: async reset between word 1 and word 2
    drive(1, 0, 0);
    drive(0, 1, 32'h1111);
    chk("t4_w1_lane0", lane_0, 32'h1111);
    chk("t4_w1_v0",    {31'd0, valid_0}, 32'd1);
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0;
    #1;
    chk("t4_async_lane0", lane_0, 32'd0);
    chk("t4_async_v0",    {31'd0, valid_0}, 32'd0);
    chk("t4_async_cnt",   {16'd0, word_cnt}, 32'd0);
    drive(0, 1, 32'h2222);
    chk("t4_w2_lane0", lane_0, 32'h2222);
    chk("t4_w2_v0v1pd", {29'd0, valid_0, valid_1, pair_done}, 32'b100);
    chk("t4_w2_lane1", lane_1, 32'd0);
    chk("t4_w2_cnt",   {16'd0, word_cnt}, 32'd1);

    // Test 5: CNT_W=4 instance, 17 continuous words
    @(negedge clk);
    reset4 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      valid4 = 1'b1; data4 = 32'h100 + i;
      @(posedge clk);
      #1;
      chk($sformatf("t5_w%0d_v", i), {30'd0, v4_0, v4_1}, (i % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("t5_w%0d_data", i), (i % 2 == 0) ? lane4_0 : lane4_1, 32'h100 + i);
      chk($sformatf("t5_w%0d_pd", i), {31'd0, pd4}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    valid4 = 1'b0;
    chk("t5_cnt_wrap", {28'd0, cnt4}, 32'd1);

    // Test 6: loopback order -- collect lane words in output order, compare with input order
    drive(1, 0, 0);
    gap_pat = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 13; i++) begin
      logic v;
      v = (i < 11) ? gap_pat[i] : 1'b0;
      w = $urandom;
      if (v) sent.push_back(w);
      drive(0, v, w);
      if (valid_0) got.push_back(lane_0);
      if (valid_1) got.push_back(lane_1);
    end
    chk("t6_count", got.size(), 32'd8);
    chk("t6_cnt",   {16'd0, word_cnt}, 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6_word%0d", i), (i < got.size()) ? got[i] : 32'hxxxxxxxx, sent[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
